ray_result_writer: RTL and testbench

Consumer end of the ray pixel stream. Ray cores issue pixels as (pixel_h, pixel_v), column-major with pixel_v fastest; this block accepts the finished results (coordinate plus colour) from the tracer pool and turns them into ordered framebuffer write transactions. It buffers results in a small FIFO, absorbs framebuffer backpressure, and computes the linear address in generation order. It also counts written pixels and signals frame completion to the frame controller.

---
 rtl/rtx_pkg.sv | 23 ++
 rtl/rtx_fifo.sv | 65 ++++++
 rtl/ray_result_writer.sv | 129 ++++++++++++
 tb/tb_ray_result_writer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtx_pkg.sv
// Shared ray-tracer definitions: frame defaults, pixel coordinate widths and
// the result record produced by the tracer pool.
package rtx_pkg;

  localparam int WIDTH_DEF   = 1280;
  localparam int HEIGHT_DEF  = 720;
  localparam int ADDR_W_DEF  = 20;
  localparam int COLOR_W_DEF = 16;

  localparam int PIX_H_W = 11;
  localparam int PIX_V_W = 10;

  typedef struct packed {
    logic [PIX_H_W-1:0]     pixel_h;
    logic [PIX_V_W-1:0]     pixel_v;
    logic [COLOR_W_DEF-1:0] color;
  } ray_result_t;

  function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/rtx_fifo.sv
// Synchronous FIFO with full/empty decoded from a registered occupancy count.
// Push while full and pop while empty are ignored.
module rtx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the occupancy count guarantees stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ray_result_writer.sv
// Turns finished ray results into ordered framebuffer writes at address
// h*HEIGHT+v, and counts written pixels to flag frame completion.
module ray_result_writer
  import rtx_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int HEIGHT  = HEIGHT_DEF,
  parameter int DEPTH   = 8,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_H_W-1:0] in_pixel_h,
  input  logic [PIX_V_W-1:0] in_pixel_v,
  input  logic [COLOR_W-1:0] in_color,
  output logic               fb_valid,
  input  logic               fb_ready,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               frame_done,
  output logic [15:0]        frame_count,
  output logic               coord_err
);

  localparam int ENTRY_W = PIX_H_W + PIX_V_W + COLOR_W;
  localparam logic [PIX_H_W:0]   H_LIM    = (PIX_H_W + 1)'(WIDTH);
  localparam logic [PIX_V_W:0]   V_LIM    = (PIX_V_W + 1)'(HEIGHT);
  localparam logic [ADDR_W-1:0]  HEIGHT_A = ADDR_W'(HEIGHT);
  localparam logic [ADDR_W-1:0]  LAST_PIX = ADDR_W'(frame_pixels(WIDTH, HEIGHT) - 1);

  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic               in_range, accept, push, load, fb_fire;
  logic [PIX_H_W-1:0] head_h;
  logic [PIX_V_W-1:0] head_v;
  logic [COLOR_W-1:0] head_color;

  logic               fb_valid_q, fb_valid_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0] fb_data_q, fb_data_d;
  logic [ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               frame_done_q, frame_done_d;
  logic               coord_err_q, coord_err_d;

  assign in_ready   = !rst && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign in_range   = ({1'b0, in_pixel_h} < H_LIM) && ({1'b0, in_pixel_v} < V_LIM);
  assign push       = accept && in_range;
  assign fifo_wdata = {in_pixel_h, in_pixel_v, in_color};
  assign {head_h, head_v, head_color} = fifo_rdata;

  // The output register refills whenever it is empty or being drained this cycle.
  assign fb_fire = fb_valid_q && fb_ready;
  assign load    = !fifo_empty && (!fb_valid_q || fb_ready);

  rtx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (load),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    fb_valid_d    = fb_valid_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    pix_cnt_d     = pix_cnt_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    coord_err_d   = coord_err_q | (accept && !in_range);

    if (load) begin
      fb_valid_d = 1'b1;
      fb_addr_d  = ADDR_W'(head_h) * HEIGHT_A + ADDR_W'(head_v);
      fb_data_d  = head_color;
    end else if (fb_fire) begin
      fb_valid_d = 1'b0;
    end

    if (fb_fire) begin
      if (pix_cnt_q == LAST_PIX) begin
        pix_cnt_d     = '0;
        frame_count_d = frame_count_q + 16'd1;
        frame_done_d  = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_valid_q    <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      pix_cnt_q     <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      coord_err_q   <= 1'b0;
    end else begin
      fb_valid_q    <= fb_valid_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      pix_cnt_q     <= pix_cnt_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      coord_err_q   <= coord_err_d;
    end
  end

  assign fb_valid    = fb_valid_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign coord_err   = coord_err_q;

endmodule

// File: tb/tb_ray_result_writer.sv
// Scoreboard bench for ray_result_writer on a 4x3 frame with a 4-entry FIFO.
module tb_ray_result_writer;
  import rtx_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int D  = 4;
  localparam int CW = 16;
  localparam int AW = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [PIX_H_W-1:0] in_pixel_h;
  logic [PIX_V_W-1:0] in_pixel_v;
  logic [CW-1:0]      in_color;
  logic               fb_valid;
  logic               fb_ready;
  logic [AW-1:0]      fb_addr;
  logic [CW-1:0]      fb_data;
  logic               frame_done;
  logic [15:0]        frame_count;
  logic               coord_err;

  always #5 clk = ~clk;

  ray_result_writer #(
    .WIDTH(W), .HEIGHT(H), .DEPTH(D), .COLOR_W(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel_h(in_pixel_h), .in_pixel_v(in_pixel_v), .in_color(in_color),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(frame_done), .frame_count(frame_count), .coord_err(coord_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   wr_cnt  = 0;
  int   done_cnt = 0;
  int   done_at = 0;

  // Scoreboard: every cycle a write is offered it must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (fb_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", fb_addr, fb_data);
        end else begin
          mon_e = exp_q[0];
          if (fb_addr !== mon_e.addr || fb_data !== mon_e.data) begin
            n_err++;
            $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                     fb_addr, fb_data, mon_e.addr, mon_e.data);
          end
          if (fb_ready) begin
            void'(exp_q.pop_front());
            wr_cnt++;
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_at = wr_cnt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Column-major pixel k of the frame: its address is k itself.
  task automatic drive(input int k);
    in_pixel_h = PIX_H_W'(k / H);
    in_pixel_v = PIX_V_W'(k % H);
    in_color   = CW'($urandom);
  endtask

  task automatic wait_drain();
    int c;
    for (c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && !fb_valid) break;
      step();
    end
    n_vec++;
    if (c == 200) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    n_vec++; if (fb_valid !== 1'b0)    begin n_err++; $display("FAIL rst_fb_valid: got %b required 0", fb_valid); end
    n_vec++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    n_vec++; if (fb_addr !== '0)       begin n_err++; $display("FAIL rst_fb_addr: got %0d required 0", fb_addr); end
    n_vec++; if (fb_data !== '0)       begin n_err++; $display("FAIL rst_fb_data: got %h required 0", fb_data); end
    n_vec++; if (frame_done !== 1'b0)  begin n_err++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    n_vec++; if (frame_count !== '0)   begin n_err++; $display("FAIL rst_frame_count: got %0d required 0", frame_count); end
    n_vec++; if (coord_err !== 1'b0)   begin n_err++; $display("FAIL rst_coord_err: got %b required 0", coord_err); end
    exp_q.delete();
    step();
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_single();
    ray_result_t r;
    r = '{pixel_h: 11'd2, pixel_v: 10'd1, color: 16'hF800};
    fb_ready   = 1'b1;
    in_pixel_h = r.pixel_h;
    in_pixel_v = r.pixel_v;
    in_color   = r.color;
    in_valid   = 1'b1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b required 1", in_ready); end
    exp_q.push_back('{addr: AW'(7), data: 16'hF800});
    step();
    in_valid = 1'b0;
    n_vec++; if (fb_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got fb_valid=%b required 0", fb_valid); end
    step();
    n_vec++; if (fb_valid !== 1'b1) begin n_err++; $display("FAIL single_latency: got fb_valid=%b required 1", fb_valid); end
    n_vec++; if (fb_addr !== AW'(7)) begin n_err++; $display("FAIL single_addr: got %0d required 7", fb_addr); end
    n_vec++; if (fb_data !== 16'hF800) begin n_err++; $display("FAIL single_data: got %h required f800", fb_data); end
    step();
    n_vec++; if (fb_valid !== 1'b0) begin n_err++; $display("FAIL single_hold: got fb_valid=%b required 0", fb_valid); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    fb_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(acc);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back('{addr: AW'(acc), data: in_color});
        acc++;
      end
      step();
    end
    in_valid = 1'b0;
    n_vec++; if (acc != D + 1)      begin n_err++; $display("FAIL bp_capacity: got %0d accepted required %0d", acc, D + 1); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low: got %b required 0", in_ready); end
    n_vec++; if (fb_valid !== 1'b1) begin n_err++; $display("FAIL bp_fb_valid: got %b required 1", fb_valid); end
    fb_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_before_pop: got %b required 0", in_ready); end
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_pop: got %b required 1", in_ready); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    fb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(k);
      in_valid = 1'b1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready: got %b required 1 at beat %0d", in_ready, k);
      end else begin
        exp_q.push_back('{addr: AW'(k), data: in_color});
      end
      step();
    end
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_coord_err();
    fb_ready   = 1'b1;
    in_pixel_h = 11'd4;
    in_pixel_v = 10'd0;
    in_color   = 16'h1234;
    in_valid   = 1'b1;
    n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL oob_in_ready: got %b required 1", in_ready); end
    n_vec++; if (coord_err !== 1'b0) begin n_err++; $display("FAIL oob_err_early: got %b required 0", coord_err); end
    step();
    in_valid = 1'b0;
    n_vec++; if (coord_err !== 1'b1) begin n_err++; $display("FAIL oob_err_set: got %b required 1", coord_err); end
    step();
    step();
    n_vec++; if (fb_valid !== 1'b0)  begin n_err++; $display("FAIL oob_no_write: got fb_valid=%b required 0", fb_valid); end
  endtask

  task automatic test_frame(input int n_frames);
    int idx = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    done_at  = 0;
    for (int c = 0; c < 400 && idx < W * H; c++) begin
      fb_ready = 1'($urandom_range(0, 1));
      drive(idx);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back('{addr: AW'(idx), data: in_color});
        idx++;
      end
      step();
    end
    in_valid = 1'b0;
    n_vec++; if (idx != W * H) begin n_err++; $display("FAIL frame_feed_timeout: got %0d sent required %0d", idx, W * H); end
    fb_ready = 1'b1;
    wait_drain();
    step();
    step();
    n_vec++; if (done_cnt != 1)      begin n_err++; $display("FAIL frame_done_count: got %0d pulses required 1", done_cnt); end
    n_vec++; if (done_at != W * H)   begin n_err++; $display("FAIL frame_done_when: got after %0d writes required %0d", done_at, W * H); end
    n_vec++; if (frame_count !== 16'(n_frames)) begin n_err++; $display("FAIL frame_count: got %0d required %0d", frame_count, n_frames); end
    n_vec++; if (dut.pix_cnt_q !== '0) begin n_err++; $display("FAIL pixel_counter: got %0d required 0", dut.pix_cnt_q); end
    n_vec++; if (coord_err !== 1'b1) begin n_err++; $display("FAIL coord_err_sticky: got %b required 1", coord_err); end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    fb_ready = 1'b0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      drive(acc);
      in_valid = 1'b1;
      if (in_ready) begin
        exp_q.push_back('{addr: AW'(acc), data: in_color});
        acc++;
      end
      step();
    end
    in_valid = 1'b0;
    n_vec++; if (fb_valid !== 1'b1) begin n_err++; $display("FAIL mid_stalled: got fb_valid=%b required 1", fb_valid); end
    rst = 1'b1;
    #1;
    n_vec++; if (fb_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_clear: got fb_valid=%b required 0", fb_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    wr_cnt = 0;
    #1;
    n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL mid_ready_release: got %b required 1", in_ready); end
    n_vec++; if (frame_count !== '0) begin n_err++; $display("FAIL mid_frame_count: got %0d required 0", frame_count); end
    fb_ready = 1'b1;
    drive(0);
    in_valid = 1'b1;
    exp_q.push_back('{addr: AW'(0), data: in_color});
    step();
    in_valid = 1'b0;
    wait_drain();
    step();
    n_vec++; if (wr_cnt != 1)        begin n_err++; $display("FAIL mid_write_count: got %0d required 1", wr_cnt); end
    n_vec++; if (frame_count !== '0) begin n_err++; $display("FAIL mid_frame_count_end: got %0d required 0", frame_count); end
    n_vec++; if (coord_err !== 1'b0) begin n_err++; $display("FAIL mid_coord_err: got %b required 0", coord_err); end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    fb_ready   = 1'b1;
    in_pixel_h = '0;
    in_pixel_v = '0;
    in_color   = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset();
    test_coord_err();
    test_frame(1);
    test_frame(2);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
